// File: rtl/wb_buffer_pkg.sv
// Shared widths, depth and drain-state encodings for the write-back buffer.
package wb_buffer_pkg;
  localparam int MemAddr  = 16;
  localparam int MemValue = 16;
  localparam int WbDepth  = 4;

  typedef enum logic {
    WbIdle = 1'b0,
    WbReq  = 1'b1
  } wb_state_t;
endpackage

// File: rtl/wb_buffer_match.sv
// DEPTH-way address comparator; among unmasked valid matches the youngest
// (closest to the tail) wins.
module wb_match #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2
) (
  input  logic [DEPTH-1:0][ADDR_W-1:0] addrs,
  input  logic [DEPTH-1:0]             valid,
  input  logic [DEPTH-1:0]             mask,
  input  logic [PTR_W-1:0]             head,
  input  logic [ADDR_W-1:0]            key,
  output logic                         hit,
  output logic [PTR_W-1:0]             idx
);
  always_comb begin
    logic [PTR_W-1:0] slot;
    hit  = 1'b0;
    idx  = head;
    slot = head;
    // Walk oldest to youngest so the last match seen is the youngest.
    for (int k = 0; k < DEPTH; k++) begin
      slot = head + PTR_W'(k);
      if (valid[slot] && !mask[slot] && addrs[slot] == key) begin
        hit = 1'b1;
        idx = slot;
      end
    end
  end
endmodule

// File: rtl/wb_buffer.sv
// Write-back buffer: queues dirty evictions, coalesces repeats, drains to SRAM
// one write per ack, and lets the miss path snoop pending data.
module wb_buffer
  import wb_buffer_pkg::*;
#(
  parameter int ADDR_W = MemAddr,
  parameter int DATA_W = MemValue,
  parameter int DEPTH  = WbDepth
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [DATA_W-1:0]        in_value,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        snoop_addr,
  output logic                     snoop_hit,
  output logic [DATA_W-1:0]        snoop_value,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_data,
  input  logic                     mem_ack,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;
  logic [DEPTH-1:0]             valid_q;
  logic [PTR_W-1:0]             head, tail, next_head;
  wb_state_t                    state;

  logic             co_hit, sn_hit, full, coalesce, alloc, pop;
  logic [PTR_W-1:0] co_idx, sn_idx;
  logic [DEPTH-1:0] co_mask;

  // Only the head actually on the bus is protected from coalescing.
  assign co_mask   = (state == WbReq) ? (DEPTH'(1) << head) : '0;
  assign full      = (count == CNT_W'(DEPTH));
  assign coalesce  = in_valid && co_hit;
  assign alloc     = in_valid && !co_hit && !full;
  assign in_ready  = !in_valid || co_hit || !full;
  assign pop       = (state == WbReq) && mem_ack;
  assign next_head = head + PTR_W'(1);
  assign empty     = (count == '0);

  assign snoop_hit   = sn_hit;
  assign snoop_value = sn_hit ? data_q[sn_idx] : '0;

  wb_match #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_coalesce (
    .addrs(addr_q), .valid(valid_q), .mask(co_mask), .head(head),
    .key(in_addr), .hit(co_hit), .idx(co_idx)
  );

  wb_match #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_snoop (
    .addrs(addr_q), .valid(valid_q), .mask('0), .head(head),
    .key(snoop_addr), .hit(sn_hit), .idx(sn_idx)
  );

  always_ff @(posedge clk) begin
    if (alloc) begin
      addr_q[tail] <= in_addr;
      data_q[tail] <= in_value;
    end else if (coalesce) begin
      data_q[co_idx] <= in_value;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
    end else begin
      if (pop) begin
        valid_q[head] <= 1'b0;
        head          <= next_head;
      end
      if (alloc) begin
        valid_q[tail] <= 1'b1;
        tail          <= tail + PTR_W'(1);
      end
      count <= count + CNT_W'(alloc) - CNT_W'(pop);
    end
  end

  // A coalesce landing on the slot being loaded this edge is forwarded so the
  // freshest data goes out on the bus.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= WbIdle;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
    end else begin
      case (state)
        WbIdle: begin
          if (count != '0) begin
            state    <= WbReq;
            mem_req  <= 1'b1;
            mem_addr <= addr_q[head];
            mem_data <= (coalesce && co_idx == head) ? in_value : data_q[head];
          end
        end
        WbReq: begin
          if (mem_ack) begin
            if (count > CNT_W'(1)) begin
              mem_addr <= addr_q[next_head];
              mem_data <= (coalesce && co_idx == next_head) ? in_value
                                                            : data_q[next_head];
            end else begin
              state   <= WbIdle;
              mem_req <= 1'b0;
            end
          end
        end
        default: state <= WbIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_buffer.sv
// Self-checking bench for wb_buffer: vector tables plus directed multi-cycle
// sequences, with a scoreboard of expected SRAM writes.
module tb_wb_buffer;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_addr, in_value;
  logic        in_ready;
  logic [15:0] snoop_addr;
  logic        snoop_hit;
  logic [15:0] snoop_value;
  logic        mem_req;
  logic [15:0] mem_addr, mem_data;
  logic        mem_ack;
  logic        empty;
  logic [2:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;
  wr_t exp_q[$];

  typedef struct {
    logic [15:0] addr;
    logic [15:0] value;
  } rt_vec_t;

  typedef struct {
    logic [15:0] probe;
    logic        hit;
    logic [15:0] value;
  } sn_vec_t;

  rt_vec_t rt_tbl[4];
  sn_vec_t sn_tbl[4];

  wb_buffer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_addr(in_addr), .in_value(in_value),
    .in_ready(in_ready),
    .snoop_addr(snoop_addr), .snoop_hit(snoop_hit), .snoop_value(snoop_value),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_ack(mem_ack), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] v);
    in_valid = 1'b1;
    in_addr  = a;
    in_value = v;
    #1;
    check("push_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic sb_push(input logic [15:0] a, input logic [15:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Waits (bounded) for a request, compares it with the scoreboard, acks it.
  task automatic do_ack();
    wr_t e;
    int  w;
    w = 0;
    while (!mem_req && w < 8) begin
      tick();
      w++;
    end
    check("ack_req_high", 32'(mem_req), 32'd1);
    if (exp_q.size() == 0) begin
      check("sb_nonempty", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("wr_addr", 32'(mem_addr), 32'(e.addr));
      check("wr_data", 32'(mem_data), 32'(e.data));
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
  endtask

  initial begin
    rt_tbl[0] = '{16'h0010, 16'hAAAA};
    rt_tbl[1] = '{16'hFFFF, 16'h0000};
    rt_tbl[2] = '{16'h0000, 16'hFFFF};
    rt_tbl[3] = '{16'h8001, 16'h5A5A};
    sn_tbl[0] = '{16'h0040, 1'b1, 16'h1234};
    sn_tbl[1] = '{16'h0044, 1'b1, 16'hBEEF};
    sn_tbl[2] = '{16'h0050, 1'b0, 16'h0000};
    sn_tbl[3] = '{16'h0000, 1'b0, 16'h0000};

    rst = 1'b0; in_valid = 1'b0; in_addr = '0; in_value = '0;
    snoop_addr = '0; mem_ack = 1'b0;
    tick(); tick();
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_data", 32'(mem_data), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    rst = 1'b1;
    tick();
    check("idle_ready", 32'(in_ready), 32'd1);
    check("idle_snoop", 32'(snoop_hit), 32'd0);

    // Single round trips: one-cycle push-to-request latency, empty after ack.
    for (int i = 0; i < 4; i++) begin
      sb_push(rt_tbl[i].addr, rt_tbl[i].value);
      push(rt_tbl[i].addr, rt_tbl[i].value);
      check("rt_req_not_yet", 32'(mem_req), 32'd0);
      tick();
      check("rt_req", 32'(mem_req), 32'd1);
      check("rt_count", 32'(count), 32'd1);
      do_ack();
      check("rt_empty", 32'(empty), 32'd1);
      check("rt_req_drop", 32'(mem_req), 32'd0);
    end

    // Snoop table, including the in-flight head and stale invalid slots.
    push(16'h0040, 16'h1234);
    push(16'h0044, 16'hBEEF);
    for (int i = 0; i < 4; i++) begin
      snoop_addr = sn_tbl[i].probe;
      #1;
      check("snoop_hit", 32'(snoop_hit), 32'(sn_tbl[i].hit));
      check("snoop_value", 32'(snoop_value), 32'(sn_tbl[i].value));
    end
    sb_push(16'h0040, 16'h1234);
    sb_push(16'h0044, 16'hBEEF);
    do_ack();
    check("snp_b2b_req", 32'(mem_req), 32'd1);
    do_ack();
    check("snp_empty", 32'(empty), 32'd1);

    // Coalesce behind an in-flight head: 0x20 merges, 0x30 keeps its order.
    push(16'h0010, 16'h0BAD);
    push(16'h0020, 16'h0001);
    push(16'h0030, 16'h0002);
    push(16'h0020, 16'h0003);
    check("co_count", 32'(count), 32'd3);
    snoop_addr = 16'h0020;
    #1;
    check("co_snoop", 32'(snoop_value), 32'h0003);
    sb_push(16'h0010, 16'h0BAD);
    sb_push(16'h0020, 16'h0003);
    sb_push(16'h0030, 16'h0002);
    do_ack();
    check("co_b2b_req1", 32'(mem_req), 32'd1);
    do_ack();
    check("co_b2b_req2", 32'(mem_req), 32'd1);
    do_ack();
    check("co_empty", 32'(empty), 32'd1);

    // Full queue: refusal, coalesce while full, push refused across a pop.
    push(16'h0100, 16'h00A0);
    push(16'h0101, 16'h00A1);
    push(16'h0102, 16'h00A2);
    push(16'h0103, 16'h00A3);
    check("full_count", 32'(count), 32'd4);
    in_valid = 1'b1; in_addr = 16'h0200; in_value = 16'h0077;
    #1;
    check("full_new_ready", 32'(in_ready), 32'd0);
    in_addr = 16'h0100;
    #1;
    check("full_head_ready", 32'(in_ready), 32'd0);
    in_addr = 16'h0102; in_value = 16'h00C2;
    #1;
    check("full_co_ready", 32'(in_ready), 32'd1);
    tick();
    check("full_co_count", 32'(count), 32'd4);
    in_addr = 16'h0200; in_value = 16'h0077;
    #1;
    check("full_pop_ready", 32'(in_ready), 32'd0);
    sb_push(16'h0100, 16'h00A0);
    sb_push(16'h0101, 16'h00A1);
    sb_push(16'h0102, 16'h00C2);
    sb_push(16'h0103, 16'h00A3);
    sb_push(16'h0200, 16'h0077);
    do_ack();
    check("full_after_pop_count", 32'(count), 32'd3);
    check("full_after_pop_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("full_refill_count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      do_ack();
      check("full_drain_count", 32'(count), 32'(3 - i));
    end
    check("full_empty", 32'(empty), 32'd1);

    // Same address as the in-flight head allocates; bus data stays put.
    push(16'h0060, 16'h1111);
    tick();
    push(16'h0060, 16'h9999);
    check("hd_count", 32'(count), 32'd2);
    check("hd_data_stable", 32'(mem_data), 32'h1111);
    snoop_addr = 16'h0060;
    #1;
    check("hd_snoop_young", 32'(snoop_value), 32'h9999);
    tick();
    check("hd_data_held", 32'(mem_data), 32'h1111);
    sb_push(16'h0060, 16'h1111);
    sb_push(16'h0060, 16'h9999);
    do_ack();
    check("hd_b2b_req", 32'(mem_req), 32'd1);
    do_ack();
    check("hd_empty", 32'(empty), 32'd1);

    // Reset mid-drain abandons everything.
    push(16'h0300, 16'h0001);
    push(16'h0301, 16'h0002);
    push(16'h0302, 16'h0003);
    check("mr_req", 32'(mem_req), 32'd1);
    check("mr_count", 32'(count), 32'd3);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("mr_req_low", 32'(mem_req), 32'd0);
    check("mr_count0", 32'(count), 32'd0);
    check("mr_empty", 32'(empty), 32'd1);
    check("mr_addr0", 32'(mem_addr), 32'd0);
    snoop_addr = 16'h0301;
    #1;
    check("mr_snoop", 32'(snoop_hit), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mr_quiet", 32'(mem_req), 32'd0);
    end

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
